// File: rtl/pwm_duty_ramp.sv
// Prescaled tick, shadow frame counter and frame-synchronous duty slew for the PWM stage.
// Define PWM_DUTY_CLAMP_EN to limit accepted targets (and therefore tau) to MAX_DUTY.
`timescale 1ns/1ps
module pwm_duty_ramp #(
  parameter int N = 8,
  parameter int PRESC_W = 16,
  parameter logic [N-1:0] MAX_DUTY = {N{1'b1}}
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PRESC_W-1:0] presc,
  input  logic [N-1:0]       step,
  input  logic [N-1:0]       target,
  input  logic               target_valid,
  output logic               target_ready,
  output logic               en_out,
  output logic [N-1:0]       tau,
  output logic               frame_start,
  output logic               busy,
  output logic               done
);

  logic [PRESC_W-1:0] presc_cnt_reg;
  logic               en_out_reg;
  logic [N-1:0]       frame_cnt_reg;
  logic [N-1:0]       tau_reg;
  logic [N-1:0]       tgt_reg;
  logic               frame_start_reg;
  logic               busy_reg;
  logic               done_reg;

  logic               boundary;
  logic               accept;
  logic [N-1:0]       eff_step;
  logic [N-1:0]       tgt_in;
  logic [N-1:0]       tau_next;
  logic [N-1:0]       tgt_next;
  logic [N:0]         sum_up;
  logic [N:0]         diff_dn;

  assign boundary     = en_out_reg && (frame_cnt_reg == {N{1'b1}});
  assign target_ready = ~boundary;
  assign accept       = target_valid && target_ready;
  assign eff_step     = (step == '0) ? {{(N-1){1'b0}}, 1'b1} : step;

`ifdef PWM_DUTY_CLAMP_EN
  assign tgt_in = (target > MAX_DUTY) ? MAX_DUTY : target;
`else
  assign tgt_in = target;
`endif

  // Extra MSB catches overshoot above all-ones and borrow below zero.
  always_comb begin
    sum_up   = {1'b0, tau_reg} + {1'b0, eff_step};
    diff_dn  = {1'b0, tau_reg} - {1'b0, eff_step};
    tau_next = tau_reg;
    if (boundary) begin
      if (tau_reg < tgt_reg)
        tau_next = (sum_up > {1'b0, tgt_reg}) ? tgt_reg : sum_up[N-1:0];
      else if (tau_reg > tgt_reg)
        tau_next = (diff_dn[N] || (diff_dn[N-1:0] < tgt_reg)) ? tgt_reg : diff_dn[N-1:0];
    end
    tgt_next = accept ? tgt_in : tgt_reg;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_cnt_reg   <= '0;
      en_out_reg      <= 1'b0;
      frame_cnt_reg   <= '0;
      tau_reg         <= '0;
      tgt_reg         <= '0;
      frame_start_reg <= 1'b0;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
    end else begin
      if (presc_cnt_reg >= presc) begin
        presc_cnt_reg <= '0;
        en_out_reg    <= 1'b1;
      end else begin
        presc_cnt_reg <= presc_cnt_reg + 1'b1;
        en_out_reg    <= 1'b0;
      end
      if (en_out_reg)
        frame_cnt_reg <= frame_cnt_reg + 1'b1;
      tau_reg         <= tau_next;
      tgt_reg         <= tgt_next;
      frame_start_reg <= boundary;
      busy_reg        <= (tau_next != tgt_next);
      // Accepts never coincide with a boundary, so tgt_reg is stable here.
      done_reg        <= boundary && (tau_reg != tgt_reg) && (tau_next == tgt_reg);
    end
  end

  assign en_out      = en_out_reg;
  assign tau         = tau_reg;
  assign frame_start = frame_start_reg;
  assign busy        = busy_reg;
  assign done        = done_reg;

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Self-checking bench for pwm_duty_ramp: reset/prescaler timing, table-driven ramps, corner sequences.
`timescale 1ns/1ps
module tb_pwm_duty_ramp;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] presc;
  logic [7:0]  step;
  logic [7:0]  target;
  logic        target_valid;
  logic        target_ready;
  logic        en_out;
  logic [7:0]  tau;
  logic        frame_start;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct packed {
    logic [7:0] tau;
    logic       done;
    logic       busy;
  } exp_t;

  typedef struct {
    logic [7:0] step;
    logic [7:0] target;
    logic [7:0] exp_tau;
    logic       exp_done;
    logic       exp_busy;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[14];

  always #5 clk = ~clk;

  pwm_duty_ramp dut (
    .clk          (clk),
    .rst          (rst),
    .presc        (presc),
    .step         (step),
    .target       (target),
    .target_valid (target_valid),
    .target_ready (target_ready),
    .en_out       (en_out),
    .tau          (tau),
    .frame_start  (frame_start),
    .busy         (busy),
    .done         (done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Present a target for one clock, skipping a boundary clock if we land on one.
  task automatic offer(input logic [7:0] t);
    int k;
    k = 0;
    @(negedge clk);
    while (!target_ready && k < 4) begin
      @(negedge clk);
      k++;
    end
    target       = t;
    target_valid = 1'b1;
    @(negedge clk);
    target_valid = 1'b0;
  endtask

  // Wait for the next frame and compare against the oldest scoreboard entry.
  task automatic frame_step();
    exp_t e;
    int   k;
    k = 0;
    @(negedge clk);
    while (frame_start !== 1'b1 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    if (frame_start !== 1'b1) begin
      n_checks++;
      n_err++;
      $display("FAIL frame_timeout: got no frame_start, required one within 2000 clocks");
    end
    if (sb_q.size() == 0) begin
      n_checks++;
      n_err++;
      $display("FAIL scoreboard_empty: got frame with no expectation, required queued entry");
    end else begin
      e = sb_q.pop_front();
      $display("frame: tau=%02h done=%0b busy=%0b | expected tau=%02h done=%0b busy=%0b",
               tau, done, busy, e.tau, e.done, e.busy);
      check("frame_tau", 32'(tau), 32'(e.tau));
      check("frame_done", 32'(done), 32'(e.done));
      check("frame_busy", 32'(busy), 32'(e.busy));
    end
    @(negedge clk);
    check("done_single_pulse", 32'(done), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion, required finish within 1 ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int first_fs;
    int second_fs;
    int k;

    vecs[0]  = '{8'h10, 8'h50, 8'h10, 1'b0, 1'b1};
    vecs[1]  = '{8'h10, 8'h50, 8'h20, 1'b0, 1'b1};
    vecs[2]  = '{8'h10, 8'h50, 8'h30, 1'b0, 1'b1};
    vecs[3]  = '{8'h10, 8'h50, 8'h40, 1'b0, 1'b1};
    vecs[4]  = '{8'h10, 8'h50, 8'h50, 1'b1, 1'b0};
    vecs[5]  = '{8'hA8, 8'hF8, 8'hF8, 1'b1, 1'b0};
    vecs[6]  = '{8'h10, 8'hFF, 8'hFF, 1'b1, 1'b0};
    vecs[7]  = '{8'hF7, 8'h08, 8'h08, 1'b1, 1'b0};
    vecs[8]  = '{8'h10, 8'h00, 8'h00, 1'b1, 1'b0};
    vecs[9]  = '{8'h05, 8'h05, 8'h05, 1'b1, 1'b0};
    vecs[10] = '{8'h00, 8'h07, 8'h06, 1'b0, 1'b1};
    vecs[11] = '{8'h00, 8'h07, 8'h07, 1'b1, 1'b0};
    vecs[12] = '{8'h10, 8'h07, 8'h07, 1'b0, 1'b0};
    vecs[13] = '{8'hFF, 8'hF0, 8'hF0, 1'b1, 1'b0};

    rst = 1'b0; presc = 16'd3; step = 8'h00; target = 8'h00; target_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tau", 32'(tau), 32'd0);
    check("rst_en_out", 32'(en_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_frame_start", 32'(frame_start), 32'd0);
    check("rst_target_ready", 32'(target_ready), 32'd1);

    // Prescaler: en_out on edges 4, 8, 12...; frame_start after edges 1025 and 2049.
    rst = 1'b1;
    first_fs = 0;
    second_fs = 0;
    for (int e = 1; e <= 2100; e++) begin
      @(posedge clk);
      #1;
      if (e <= 16)
        check($sformatf("presc_en_edge%0d", e), 32'(en_out), (e % 4 == 0) ? 32'd1 : 32'd0);
      if (frame_start === 1'b1) begin
        if (first_fs == 0) first_fs = e;
        else if (second_fs == 0) second_fs = e;
      end
    end
    check("first_frame_start_edge", 32'(first_fs), 32'd1025);
    check("second_frame_start_edge", 32'(second_fs), 32'd2049);

    presc = 16'd0;
    @(negedge clk);
    for (int i = 0; i < 14; i++) begin
      step = vecs[i].step;
      offer(vecs[i].target);
      sb_q.push_back('{tau: vecs[i].exp_tau, done: vecs[i].exp_done, busy: vecs[i].exp_busy});
      frame_step();
    end

    // Offer on the boundary clock: refused there, accepted one clock later.
    step = 8'h10;
    k = 0;
    @(negedge clk);
    while (target_ready && k < 600) begin
      @(negedge clk);
      k++;
    end
    check("ready_low_at_boundary", 32'(target_ready), 32'd0);
    target = 8'h00;
    target_valid = 1'b1;
    @(negedge clk);
    check("collision_frame_start", 32'(frame_start), 32'd1);
    check("collision_tau_old_tgt", 32'(tau), 32'hF0);
    check("collision_not_accepted", 32'(busy), 32'd0);
    @(negedge clk);
    target_valid = 1'b0;
    check("accept_after_boundary", 32'(busy), 32'd1);
    sb_q.push_back('{tau: 8'hE0, done: 1'b0, busy: 1'b1});
    frame_step();

    // Asynchronous reset mid-ramp.
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_tau", 32'(tau), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_en_out", 32'(en_out), 32'd0);
    check("async_rst_ready", 32'(target_ready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Retarget mid-ramp: up toward 0x80, then back to 0x10 from 0x30.
    step = 8'h10;
    offer(8'h80);
    sb_q.push_back('{tau: 8'h10, done: 1'b0, busy: 1'b1});
    frame_step();
    sb_q.push_back('{tau: 8'h20, done: 1'b0, busy: 1'b1});
    frame_step();
    sb_q.push_back('{tau: 8'h30, done: 1'b0, busy: 1'b1});
    frame_step();
    offer(8'h10);
    sb_q.push_back('{tau: 8'h20, done: 1'b0, busy: 1'b1});
    frame_step();
    sb_q.push_back('{tau: 8'h10, done: 1'b1, busy: 1'b0});
    frame_step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/pwm_duty_ramp.md
Name: pwm_duty_ramp

Overview:
- Upstream feeder for the team's PWM counter/comparator stage (duty input `tau`, count enable `EN`, free-running N-bit counter).
- Generates the prescaled tick that drives the PWM's `EN`, and tracks the PWM frame with a shadow counter.
- Slews the duty value toward a requested target by a programmable step, updating only at frame boundaries, so the PWM never sees a mid-period duty change.
- Gives soft-start/soft-stop for motor/LED loads.

Parameters:
N, 8, duty/frame width; must equal the PWM stage's n
PRESC_W, 16, prescaler divide-value width
MAX_DUTY, 2**N-1, duty ceiling; used only when PWM_DUTY_CLAMP_EN is defined

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-low
presc  in  PRESC_W  tick divide value; one en_out pulse per presc+1 clocks
step  in  N  duty increment/decrement per frame; 0 is treated as 1
target  in  N  requested duty
target_valid  in  1  target offer
target_ready  out  1  target accepted when valid && ready
en_out  out  1  one-cycle tick; connects to the PWM's EN
tau  out  N  current duty; connects to the PWM's tau
frame_start  out  1  one-cycle pulse, registered, on the first clock after a frame wrap
busy  out  1  tau != target register
done  out  1  one-cycle pulse when a ramp reaches its target

Behaviour:
- Reset (rst=0, asynchronous):
  - Outputs: en_out=0, tau=0, frame_start=0, busy=0, done=0.
  - Internal state: presc_cnt=0, frame_cnt=0, tgt_reg=0.
  - target_ready is combinational, so it reads 1 during reset.
  - Reset mid-ramp aborts immediately; tau returns to 0 with no ramp-down.
- Prescaler:
  - If presc_cnt >= presc, then presc_cnt<=0 and en_out<=1; otherwise presc_cnt+1 and en_out<=0.
  - The >= comparison means a presc reduced below the current count wraps on the next clock.
  - presc=0 gives en_out high every clock.
  - First en_out rises presc+1 clocks after reset release.
- Frame tracking:
  - frame_cnt increments, N bits, on each clock with en_out=1, wrapping all-ones to 0.
  - This mirrors the PWM counter, which shares the same reset and EN.
  - boundary = en_out && frame_cnt==all-ones.
- Duty update, at boundary only. Arithmetic is in N+1 bits, with eff_step = (step==0)?1:step.
  - tau<tgt_reg: tau<=min(tau+eff_step, tgt_reg).
  - tau>tgt_reg: tau<=max(tau-eff_step, tgt_reg); never wraps below 0.
  - equal: tau unchanged.
  - The new tau is presented from the clock in which the PWM counter is 0, i.e. from the start of the next frame.
- done: registered pulse for the clock after the boundary at which tau becomes equal to tgt_reg, having differed before.
  - An accepted target equal to the current tau sets neither busy nor done.
- busy: registered (tau != tgt_reg).
- Handshake:
  - target_ready = ~boundary (combinational); low only in the boundary clock.
  - On accept, tgt_reg<=target. Retargeting mid-ramp is allowed; the ramp direction follows the new tgt_reg from the next boundary.
  - busy/done reflect the new target one clock after accept.
- frame_start <= boundary.
- step or presc changes take effect at the next use; no latching.

Optional Feature:
- Macro: PWM_DUTY_CLAMP_EN.
- Defined:
  - An accepted target > MAX_DUTY is stored as MAX_DUTY.
  - tau never exceeds MAX_DUTY.
- Undefined:
  - MAX_DUTY is ignored and targets are stored verbatim.
  - No comparator is synthesized.

Test Plan:
- Reset/prescaler, N=8: hold rst=0 with presc=3 → tau=0, en_out=0, busy=0, target_ready=1. Release → en_out pulses on clocks 4, 8, 12…; frame_start pulses once per 1024 clocks.
- Ramp up: presc=0, step=0x10, accept target=0x50 → tau steps 0x10, 0x20, 0x30, 0x40, 0x50 at successive frame boundaries (every 256 clocks); single done pulse after the 0x50 update; busy 1→0 at that clock.
- Saturating edges: tau=0xF8, target=0xFF, step=0x10 → tau=0xFF in one frame, no wrap. tau=0x08, target=0x00 → tau=0x00, not 0xF8. step=0 with tau=0x05, target=0x07 → 0x06, then 0x07.
- Handshake collision: assert target_valid=1 exactly on the boundary clock → target_ready=0, no accept. Target accepted the next clock. The boundary's tau update uses the old tgt_reg.
- Retarget and reset mid-ramp: ramp 0x00→0x80 step 0x10. At tau=0x30 accept 0x10 → next boundaries give 0x20, 0x10, then done. Pull rst low mid-ramp → tau=0 asynchronously, before the next clk edge.
- Clamp: with PWM_DUTY_CLAMP_EN and MAX_DUTY=0xC0, target=0xF0 → tau settles at 0xC0, done pulses. Without the macro → tau settles at 0xF0.
